// File: rtl/multi_issue_queue.sv
// Circular multi-issue queue between decode and issue: all-or-nothing bundle
// pushes of up to PUSH_W entries, in-order presentation and pop of up to POP_W.
module multi_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int PUSH_W = 4,
  parameter int POP_W  = 2,
  parameter int DATA_W = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flash,
  input  logic                            stall,
  input  logic [PUSH_W*DATA_W-1:0]        in_data,
  input  logic [$clog2(PUSH_W+1)-1:0]     in_data_number,
  output logic                            push_accept,
  output logic [$clog2(DEPTH+1)-1:0]      iq_size_left,
  output logic [$clog2(DEPTH+1)-1:0]      iq_count,
  output logic [$clog2(POP_W+1)-1:0]      iq_size,
  output logic [POP_W*DATA_W-1:0]         out_data,
  input  logic [$clog2(POP_W+1)-1:0]      out_data_number,
  output logic                            overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(POP_W + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     count;
  logic [OW-1:0]     pop_eff;
  logic              push_err;
  logic              pop_err;

  // The wrap bit in both pointers lets a full queue be told apart from an empty one.
  assign count        = tail - head;
  assign iq_count     = CW'(count);
  assign iq_size_left = CW'(DEPTH) - iq_count;
  assign iq_size      = (count >= PW'(POP_W)) ? OW'(POP_W) : OW'(count);

  // Capacity is judged on the pre-pop occupancy; no same-cycle pop credit.
  assign push_err    = CW'(in_data_number) > iq_size_left;
  assign pop_err     = !stall && (out_data_number > iq_size);
  assign push_accept = !flash && !push_err;

  always_comb begin
    pop_eff = '0;
    if (!stall && !flash)
      pop_eff = (out_data_number < iq_size) ? out_data_number : iq_size;
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < POP_W; j++) begin
      if (OW'(j) < iq_size)
        out_data[j*DATA_W +: DATA_W] = mem[head[AW-1:0] + AW'(j)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      overflow_err <= 1'b0;
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= '0;
    end else if (flash) begin
      // Flush drops pointers only; storage and the error flag survive.
      head <= '0;
      tail <= '0;
    end else begin
      if (push_accept) begin
        for (int i = 0; i < PUSH_W; i++) begin
          if (($clog2(PUSH_W+1))'(i) < in_data_number)
            mem[tail[AW-1:0] + AW'(i)] <= in_data[i*DATA_W +: DATA_W];
        end
        tail <= tail + PW'(in_data_number);
      end
      head <= head + PW'(pop_eff);
      if (push_err || pop_err)
        overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_issue_queue.sv
// Directed table-driven bench for multi_issue_queue plus hand sequences for
// steady-state wrap-around and asynchronous mid-cycle reset.
module tb_multi_issue_queue;

  localparam int DEPTH  = 8;
  localparam int PUSH_W = 4;
  localparam int POP_W  = 2;
  localparam int DATA_W = 64;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flash = 1'b0;
  logic                  stall = 1'b0;
  logic [PUSH_W*DATA_W-1:0] in_data = '0;
  logic [2:0]            in_data_number = '0;
  logic                  push_accept;
  logic [3:0]            iq_size_left;
  logic [3:0]            iq_count;
  logic [1:0]            iq_size;
  logic [POP_W*DATA_W-1:0] out_data;
  logic [1:0]            out_data_number = '0;
  logic                  overflow_err;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        st;
    logic [2:0]  n;
    logic [255:0] d;
    logic [1:0]  pop;
    logic        acc;
    logic [3:0]  cnt;
    logic [3:0]  left;
    logic [1:0]  sz;
    logic [63:0] o0;
    logic [63:0] o1;
    logic        err;
  } vec_t;

  vec_t vecs[17];

  multi_issue_queue #(
    .DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flash(flash),
    .stall(stall),
    .in_data(in_data),
    .in_data_number(in_data_number),
    .push_accept(push_accept),
    .iq_size_left(iq_size_left),
    .iq_count(iq_count),
    .iq_size(iq_size),
    .out_data(out_data),
    .out_data_number(out_data_number),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] bundle(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic [63:0] e);
    return {e, c, b, a};
  endfunction

  function automatic vec_t mk(input logic rst, input logic fl, input logic st,
                              input logic [2:0] n, input logic [255:0] d,
                              input logic [1:0] pop, input logic acc,
                              input logic [3:0] cnt, input logic [3:0] left,
                              input logic [1:0] sz, input logic [63:0] o0,
                              input logic [63:0] o1, input logic err);
    vec_t v;
    v.rst = rst; v.fl = fl; v.st = st; v.n = n; v.d = d; v.pop = pop;
    v.acc = acc; v.cnt = cnt; v.left = left; v.sz = sz; v.o0 = o0; v.o1 = o1;
    v.err = err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    if (v.rst) begin
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
    end
    flash = v.fl;
    stall = v.st;
    in_data_number = v.n;
    in_data = v.d;
    out_data_number = v.pop;
    #1;
    checkOutput($sformatf("v%0d_accept", idx), 64'(push_accept), 64'(v.acc));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d_count", idx), 64'(iq_count), 64'(v.cnt));
    checkOutput($sformatf("v%0d_left", idx), 64'(iq_size_left), 64'(v.left));
    checkOutput($sformatf("v%0d_size", idx), 64'(iq_size), 64'(v.sz));
    checkOutput($sformatf("v%0d_out0", idx), out_data[63:0], v.o0);
    checkOutput($sformatf("v%0d_out1", idx), out_data[127:64], v.o1);
    checkOutput($sformatf("v%0d_err", idx), 64'(overflow_err), 64'(v.err));
  endtask

  initial begin
    logic [63:0] model[$];
    logic [63:0] next_val;
    logic [63:0] tmp;

    //           rst fl st n  data                          pop acc cnt left sz o0   o1   err
    vecs[0]  = mk(1, 0, 0, 0, '0,                            0, 1,  0,  8,  0, 0,   0,   0);
    vecs[1]  = mk(0, 0, 0, 4, bundle(1, 2, 3, 4),            0, 1,  4,  4,  2, 1,   2,   0);
    vecs[2]  = mk(0, 0, 0, 4, bundle(5, 6, 7, 8),            0, 1,  8,  0,  2, 1,   2,   0);
    vecs[3]  = mk(0, 0, 0, 1, bundle(9, 0, 0, 0),            0, 0,  8,  0,  2, 1,   2,   1);
    vecs[4]  = mk(0, 0, 0, 0, '0,                            0, 1,  8,  0,  2, 1,   2,   1);
    vecs[5]  = mk(0, 0, 0, 0, '0,                            2, 1,  6,  2,  2, 3,   4,   1);
    vecs[6]  = mk(0, 0, 0, 2, bundle(10, 11, 0, 0),          2, 1,  6,  2,  2, 5,   6,   1);
    vecs[7]  = mk(0, 0, 0, 3, bundle(12, 13, 14, 0),         0, 0,  6,  2,  2, 5,   6,   1);
    vecs[8]  = mk(1, 0, 0, 3, bundle(21, 22, 23, 0),         0, 1,  3,  5,  2, 21,  22,  0);
    vecs[9]  = mk(0, 0, 1, 0, '0,                            2, 1,  3,  5,  2, 21,  22,  0);
    vecs[10] = mk(0, 0, 1, 1, bundle(24, 0, 0, 0),           2, 1,  4,  4,  2, 21,  22,  0);
    vecs[11] = mk(1, 0, 0, 4, bundle(31, 32, 33, 34),        0, 1,  4,  4,  2, 31,  32,  0);
    vecs[12] = mk(0, 0, 0, 1, bundle(35, 0, 0, 0),           0, 1,  5,  3,  2, 31,  32,  0);
    vecs[13] = mk(0, 1, 0, 3, bundle(36, 37, 38, 0),         2, 0,  0,  8,  0, 0,   0,   0);
    vecs[14] = mk(0, 0, 0, 2, bundle(41, 42, 0, 0),          0, 1,  2,  6,  2, 41,  42,  0);
    vecs[15] = mk(1, 0, 0, 1, bundle(51, 0, 0, 0),           0, 1,  1,  7,  1, 51,  0,   0);
    vecs[16] = mk(0, 0, 0, 0, '0,                            2, 1,  0,  8,  0, 0,   0,   1);

    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++)
      applyStimulus(i, vecs[i]);

    // Steady state: count held at 4 while pushing 2 and popping 2, wrapping the array.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    flash = 1'b0;
    stall = 1'b0;
    out_data_number = 2'd0;
    in_data_number = 3'd4;
    in_data = bundle(100, 101, 102, 103);
    for (int k = 0; k < 4; k++) model.push_back(64'(100 + k));
    @(posedge clk);
    #1;
    checkOutput("steady_prefill_count", 64'(iq_count), 64'd4);
    next_val = 64'd104;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_data_number = 3'd2;
      in_data = bundle(next_val, next_val + 1, 0, 0);
      out_data_number = 2'd2;
      model.push_back(next_val);
      model.push_back(next_val + 1);
      next_val = next_val + 2;
      @(posedge clk);
      #1;
      tmp = model.pop_front();
      tmp = model.pop_front();
      checkOutput($sformatf("steady%0d_count", c), 64'(iq_count), 64'd4);
      checkOutput($sformatf("steady%0d_out0", c), out_data[63:0], model[0]);
      checkOutput($sformatf("steady%0d_out1", c), out_data[127:64], model[1]);
    end
    checkOutput("steady_err", 64'(overflow_err), 64'd0);

    // Asynchronous reset between clock edges clears state with no edge needed.
    @(negedge clk);
    in_data_number = 3'd0;
    out_data_number = 2'd0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_count", 64'(iq_count), 64'd0);
    checkOutput("async_rst_out0", out_data[63:0], 64'd0);
    checkOutput("async_rst_left", 64'(iq_size_left), 64'd8);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
